mem_ctrl: RTL and testbench

Byte-serial memory controller between the pipeline and the single-port 8-bit RAM/IO bus. It arbitrates instruction fetches from IF and data loads/stores from MEM, and assembles or splits 32-bit words over successive byte cycles. It raises the MEM stall request that the stall controller folds into the `stall_state` bus consumed by the pipeline registers. It sits between the IF/MEM stages and the top-level RAM pins.

---
 rtl/mem_ctrl_pkg.sv | 46 ++++
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-serial memory controller:
// bus widths, access size codes, FSM encodings and the IO window base.
package mem_ctrl_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [31:0] IO_WINDOW = 32'h0003_0000;

  // Number of byte cycles for a MEM access; code 3 behaves as a word.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      SIZE_B:  size_len = 3'd1;
      SIZE_H:  size_len = 3'd2;
      SIZE_W:  size_len = 3'd4;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [RegBus-1:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response signals plus the 8-bit RAM/IO pins of mem_ctrl.
// master = pipeline and RAM side, slave = the controller.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
  import mem_ctrl_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [RegBus-1:0] if_data;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [RegBus-1:0] mem_wdata;
  logic              mem_done;
  logic [RegBus-1:0] mem_rdata;
  logic              mem_stall_req;

  logic              io_buffer_full;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output io_buffer_full, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, mem_stall_req, ram_a, ram_dout, ram_wr
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  io_buffer_full, ram_din,
    output if_done, if_data, mem_done, mem_rdata, mem_stall_req, ram_a, ram_dout, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller: MEM-over-IF arbitration, word assembly/split; word read done
// 6 cycles after acceptance. Stalls on rdy low and on IO-window writes while io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = InstAddrBus,
  parameter logic [31:0] IO_BASE = IO_WINDOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  logic [1:0]        state_q;
  logic              owner_q;
  logic [2:0]        cnt_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] base_q;
  logic [RegBus-1:0] wdata_q;
  logic [RegBus-1:0] asm_q;
  logic [RegBus-1:0] asm_nxt;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [RegBus-1:0] if_data_q;
  logic [RegBus-1:0] mem_rdata_q;

  logic [2:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_inc;
  logic              wr_blocked;

  assign cnt_inc  = cnt_q + 3'd1;
  assign addr_inc = base_q + ADDR_W'(cnt_inc);

  // A write into a full IO sink is withheld in the very cycle it would happen.
  assign wr_blocked = (state_q == S_WRITE) && bus.io_buffer_full &&
                      (ram_a_q[17:16] == IO_BASE[17:16]);

  // The byte on ram_din belongs to the address issued in the previous READ cycle.
  always_comb begin
    asm_nxt = asm_q;
    case (cnt_q)
      3'd1:    asm_nxt[7:0]   = bus.ram_din;
      3'd2:    asm_nxt[15:8]  = bus.ram_din;
      3'd3:    asm_nxt[23:16] = bus.ram_din;
      3'd4:    asm_nxt[31:24] = bus.ram_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= ZeroWord;
      asm_q       <= ZeroWord;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= False;
      if_done_q   <= False;
      mem_done_q  <= False;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
    end else if (rdy) begin
      if_done_q  <= False;
      mem_done_q <= False;
      case (state_q)
        S_IDLE: begin
          if (bus.mem_req) begin
            owner_q <= OWN_MEM;
            base_q  <= bus.mem_addr;
            len_q   <= size_len(bus.mem_size);
            wdata_q <= bus.mem_wdata;
            cnt_q   <= '0;
            asm_q   <= ZeroWord;
            ram_a_q <= bus.mem_addr;
            if (bus.mem_we) begin
              state_q    <= S_WRITE;
              ram_dout_q <= bus.mem_wdata[7:0];
              ram_wr_q   <= True;
            end else begin
              state_q <= S_READ;
            end
          end else if (bus.if_req && !bus.if_flush) begin
            owner_q <= OWN_IF;
            base_q  <= bus.if_addr;
            len_q   <= 3'd4;
            cnt_q   <= '0;
            asm_q   <= ZeroWord;
            ram_a_q <= bus.if_addr;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (owner_q == OWN_IF && bus.if_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ram_a_q <= '0;
          end else begin
            asm_q <= asm_nxt;
            if (cnt_q == len_q) begin
              state_q <= S_DONE;
              cnt_q   <= '0;
              ram_a_q <= '0;
              if (owner_q == OWN_IF) begin
                if_done_q <= True;
                if_data_q <= asm_nxt;
              end else begin
                mem_done_q  <= True;
                mem_rdata_q <= asm_nxt;
              end
            end else begin
              cnt_q   <= cnt_inc;
              ram_a_q <= (cnt_inc < len_q) ? addr_inc : '0;
            end
          end
        end
        S_WRITE: begin
          if (!wr_blocked) begin
            if (cnt_q == len_q - 3'd1) begin
              state_q     <= S_DONE;
              cnt_q       <= '0;
              ram_a_q     <= '0;
              ram_dout_q  <= '0;
              ram_wr_q    <= False;
              mem_done_q  <= True;
              mem_rdata_q <= asm_q;
            end else begin
              cnt_q      <= cnt_inc;
              ram_a_q    <= addr_inc;
              ram_dout_q <= byte_sel(wdata_q, cnt_inc[1:0]);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.ram_a         = ram_a_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q & rdy & ~wr_blocked;
  assign bus.if_done       = if_done_q & ~bus.if_flush;
  assign bus.if_data       = if_data_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_stall_req = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transfers queue the expected bus cycles and done
// pulses; a negedge monitor pops and compares whatever the controller presents.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
  } bus_ev_t;

  typedef struct {
    int          cyc;
    logic        is_if;
    logic        chk;
    logic [31:0] data;
  } done_ev_t;

  bit   clk;
  logic rst;
  logic rdy;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   zchk;
  int   t;

  logic [7:0] ram [int];
  bus_ev_t    exp_bus[$];
  done_ev_t   exp_done[$];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM answers one cycle after the address.
  always @(posedge clk)
    bus.ram_din <= ram.exists(int'(bus.ram_a)) ? ram[int'(bus.ram_a)] : 8'h00;

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_rd(input int c, input logic [31:0] a);
    exp_bus.push_back('{c, a, 1'b0, 8'h00});
  endtask

  task automatic exp_wr(input int c, input logic [31:0] a, input logic w, input logic [7:0] d);
    exp_bus.push_back('{c, a, w, d});
  endtask

  task automatic exp_dn(input int c, input logic is_if, input logic chk, input logic [31:0] d);
    exp_done.push_back('{c, is_if, chk, d});
  endtask

  task automatic chk_done(input logic is_if, input logic [31:0] d);
    done_ev_t e;
    n_cmp++;
    if (exp_done.size() == 0) begin
      n_bad++;
      $display("FAIL done_event: unexpected %s done at cycle %0d data=%h, required none",
               is_if ? "if" : "mem", cyc, d);
    end else begin
      e = exp_done.pop_front();
      if (e.cyc != cyc || e.is_if != is_if || (e.chk && e.data !== d) ||
          (!is_if && bus.mem_stall_req !== 1'b0)) begin
        n_bad++;
        $display("FAIL done_event: got %s done cycle %0d data=%h stall=%b, required %s done cycle %0d data=%h stall=0",
                 is_if ? "if" : "mem", cyc, d, bus.mem_stall_req,
                 e.is_if ? "if" : "mem", e.cyc, e.data);
      end
    end
  endtask

  task automatic monitor();
    bus_ev_t e;
    forever begin
      @(negedge clk);
      if (zchk) begin
        n_cmp++;
        if (bus.ram_a !== '0 || bus.ram_wr !== 1'b0 || bus.ram_dout !== 8'h00 ||
            bus.if_done !== 1'b0 || bus.mem_done !== 1'b0 || bus.if_data !== '0 ||
            bus.mem_rdata !== '0 || bus.mem_stall_req !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_zero: ram_a=%h wr=%b dout=%h if_done=%b mem_done=%b if_data=%h mem_rdata=%h stall=%b, required all 0",
                   bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.mem_done,
                   bus.if_data, bus.mem_rdata, bus.mem_stall_req);
        end
        zchk = 1'b0;
      end
      if (bus.ram_a != '0 || bus.ram_wr) begin
        n_cmp++;
        if (exp_bus.size() == 0) begin
          n_bad++;
          $display("FAIL bus_event: unexpected cycle %0d ram_a=%h wr=%b dout=%h, required idle bus",
                   cyc, bus.ram_a, bus.ram_wr, bus.ram_dout);
        end else begin
          e = exp_bus.pop_front();
          if (e.cyc != cyc || e.addr !== bus.ram_a || e.wr !== bus.ram_wr || e.dout !== bus.ram_dout) begin
            n_bad++;
            $display("FAIL bus_event: got cycle %0d ram_a=%h wr=%b dout=%h, required cycle %0d ram_a=%h wr=%b dout=%h",
                     cyc, bus.ram_a, bus.ram_wr, bus.ram_dout, e.cyc, e.addr, e.wr, e.dout);
          end
        end
      end
      if (bus.if_done)  chk_done(1'b1, bus.if_data);
      if (bus.mem_done) chk_done(1'b0, bus.mem_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_size = SIZE_B;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.io_buffer_full = 1'b0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h85;
    ram[32'h300] = 8'h11; ram[32'h301] = 8'h22; ram[32'h302] = 8'h33; ram[32'h303] = 8'h44;

    fork
      monitor();
    join_none

    #2 rst = 1'b0;
    zchk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    goto(cyc + 2);

    // Word fetch
    t = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    for (int k = 0; k < 4; k++) exp_rd(t + 1 + k, 32'h100 + k);
    exp_dn(t + 6, 1'b1, 1'b1, 32'h0000_0013);
    goto(t + 7); bus.if_req = 1'b0;
    goto(t + 9);

    // Simultaneous IF and MEM byte load: MEM first, fetch after DONE
    t = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    bus.mem_we = 1'b0; bus.mem_size = SIZE_B; bus.mem_addr = 32'h200; bus.mem_req = 1'b1;
    exp_rd(t + 1, 32'h200);
    exp_dn(t + 3, 1'b0, 1'b1, 32'h0000_0085);
    for (int k = 0; k < 4; k++) exp_rd(t + 5 + k, 32'h100 + k);
    exp_dn(t + 10, 1'b1, 1'b1, 32'h0000_0013);
    goto(t + 4); bus.mem_req = 1'b0;
    goto(t + 11); bus.if_req = 1'b0;
    goto(t + 13);

    // Half store outside the IO window ignores io_buffer_full
    t = cyc;
    bus.io_buffer_full = 1'b1;
    bus.mem_we = 1'b1; bus.mem_size = SIZE_H; bus.mem_addr = 32'h40;
    bus.mem_wdata = 32'hAABB_CCDD; bus.mem_req = 1'b1;
    exp_wr(t + 1, 32'h40, 1'b1, 8'hDD);
    exp_wr(t + 2, 32'h41, 1'b1, 8'hCC);
    exp_dn(t + 3, 1'b0, 1'b0, 32'h0);
    goto(t + 4); bus.mem_req = 1'b0; bus.io_buffer_full = 1'b0;
    goto(t + 6);

    // Flush in cycle 3 of a fetch, then a clean refetch
    t = cyc;
    bus.if_addr = 32'h300; bus.if_req = 1'b1;
    for (int k = 0; k < 3; k++) exp_rd(t + 1 + k, 32'h300 + k);
    for (int k = 0; k < 4; k++) exp_rd(t + 5 + k, 32'h300 + k);
    exp_dn(t + 10, 1'b1, 1'b1, 32'h4433_2211);
    goto(t + 3); bus.if_flush = 1'b1;
    goto(t + 4); bus.if_flush = 1'b0;
    goto(t + 11); bus.if_req = 1'b0;
    goto(t + 13);

    // Flush and MEM request in the same cycle: MEM accepted from IDLE next cycle
    t = cyc;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    exp_rd(t + 1, 32'h100);
    exp_rd(t + 2, 32'h101);
    exp_rd(t + 4, 32'h200);
    exp_dn(t + 6, 1'b0, 1'b1, 32'h0000_0085);
    for (int k = 0; k < 4; k++) exp_rd(t + 8 + k, 32'h100 + k);
    exp_dn(t + 13, 1'b1, 1'b1, 32'h0000_0013);
    goto(t + 2);
    bus.if_flush = 1'b1;
    bus.mem_we = 1'b0; bus.mem_size = SIZE_B; bus.mem_addr = 32'h200; bus.mem_req = 1'b1;
    goto(t + 3); bus.if_flush = 1'b0;
    goto(t + 7); bus.mem_req = 1'b0;
    goto(t + 14); bus.if_req = 1'b0;
    goto(t + 16);

    // IO byte store held off for three cycles by a full sink
    t = cyc;
    bus.mem_we = 1'b1; bus.mem_size = SIZE_B; bus.mem_addr = 32'h3_0000;
    bus.mem_wdata = 32'h0000_005A; bus.mem_req = 1'b1;
    for (int k = 1; k <= 3; k++) exp_wr(t + k, 32'h3_0000, 1'b0, 8'h5A);
    exp_wr(t + 4, 32'h3_0000, 1'b1, 8'h5A);
    exp_dn(t + 5, 1'b0, 1'b0, 32'h0);
    goto(t + 1); bus.io_buffer_full = 1'b1;
    goto(t + 4); bus.io_buffer_full = 1'b0;
    goto(t + 6); bus.mem_req = 1'b0;
    goto(t + 8);

    // rdy low freezes a byte store and masks ram_wr
    t = cyc;
    bus.mem_we = 1'b1; bus.mem_size = SIZE_B; bus.mem_addr = 32'h500;
    bus.mem_wdata = 32'h0000_0077; bus.mem_req = 1'b1;
    exp_wr(t + 1, 32'h500, 1'b0, 8'h77);
    exp_wr(t + 2, 32'h500, 1'b0, 8'h77);
    exp_wr(t + 3, 32'h500, 1'b1, 8'h77);
    exp_dn(t + 4, 1'b0, 1'b0, 32'h0);
    goto(t + 1); rdy = 1'b0;
    goto(t + 3); rdy = 1'b1;
    goto(t + 5); bus.mem_req = 1'b0;
    goto(t + 7);

    // Reset in cycle 3 of a word load, then a fresh load
    t = cyc;
    bus.mem_we = 1'b0; bus.mem_size = SIZE_W; bus.mem_addr = 32'h300; bus.mem_req = 1'b1;
    exp_rd(t + 1, 32'h300);
    exp_rd(t + 2, 32'h301);
    goto(t + 3); rst = 1'b0; bus.mem_req = 1'b0; zchk = 1'b1;
    goto(t + 5); rst = 1'b1;
    goto(t + 12);
    t = cyc;
    bus.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) exp_rd(t + 1 + k, 32'h300 + k);
    exp_dn(t + 6, 1'b0, 1'b1, 32'h4433_2211);
    goto(t + 7); bus.mem_req = 1'b0;
    goto(t + 12);

    n_cmp++;
    if (exp_bus.size() != 0 || exp_done.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d bus events and %0d done pulses still pending, required 0 and 0",
               exp_bus.size(), exp_done.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
